// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: one outstanding imem request, stall buffer, redirect with kill
module fetch_stage #(
    parameter int                XLEN      = 32,
    parameter int                ILEN      = 32,
    parameter logic [XLEN-1:0]   RESET_PC  = 'h0000_1000,
    parameter logic [ILEN-1:0]   NOP_INSTR = 'h0000_0013
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall_in,
    input  logic                 redirect_in,
    input  logic [XLEN-1:0]      redirect_pc_in,
    output logic                 imem_req_out,
    output logic [XLEN-1:0]      imem_addr_out,
    input  logic                 imem_ready_in,
    input  logic                 imem_resp_valid_in,
    input  logic [ILEN-1:0]      imem_resp_data_in,
    output logic [ILEN-1:0]      instr_out,
    output logic [XLEN-1:0]      pc_out,
    output logic [XLEN-1:0]      pc_plus4_out,
    output logic                 xcpt_out
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_t              r_state;
    logic [XLEN-1:0]     r_pc;
    logic                r_kill;
    logic [ILEN-1:0]     r_ibuf;
    logic                r_xcpt;

    logic [XLEN-1:0]     w_pc_plus4;
    logic                w_resp_usable;
    logic                w_deliver;
    logic                w_misaligned;

    assign w_pc_plus4    = r_pc + PC_STEP;
    assign w_misaligned  = |redirect_pc_in[1:0];
    // A response is only usable when it belongs to the current PC (not killed by an earlier redirect).
    assign w_resp_usable = (r_state == S_WAIT) & imem_resp_valid_in & ~r_kill;
    assign w_deliver     = w_resp_usable & ~stall_in & ~redirect_in;

    assign pc_out        = r_pc;
    assign pc_plus4_out  = w_pc_plus4;
    assign imem_addr_out = r_pc;
    assign xcpt_out      = r_xcpt;
    assign imem_req_out  = ~reset & (r_state == S_REQ) & ~redirect_in;

    always_comb begin
        instr_out = NOP_INSTR;
        if (!reset) begin
            if (w_deliver)
                instr_out = imem_resp_data_in;
            else if ((r_state == S_HOLD) && !redirect_in)
                instr_out = r_ibuf;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_kill  <= 1'b0;
            r_ibuf  <= NOP_INSTR;
            r_xcpt  <= 1'b0;
        end else begin
            r_xcpt <= redirect_in & w_misaligned;
            if (redirect_in) begin
                r_pc <= redirect_pc_in;
                // With a request still in flight the stale response must be swallowed before reissuing.
                if ((r_state == S_WAIT) && !imem_resp_valid_in) begin
                    r_state <= S_WAIT;
                    r_kill  <= 1'b1;
                end else begin
                    r_state <= S_REQ;
                    r_kill  <= 1'b0;
                end
            end else begin
                case (r_state)
                    S_REQ: begin
                        if (imem_ready_in)
                            r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (imem_resp_valid_in) begin
                            if (r_kill) begin
                                r_kill  <= 1'b0;
                                r_state <= S_REQ;
                            end else if (stall_in) begin
                                r_ibuf  <= imem_resp_data_in;
                                r_state <= S_HOLD;
                            end else begin
                                r_pc    <= w_pc_plus4;
                                r_state <= S_REQ;
                            end
                        end
                    end
                    S_HOLD: begin
                        if (!stall_in) begin
                            r_pc    <= w_pc_plus4;
                            r_state <= S_REQ;
                        end
                    end
                    default: r_state <= S_REQ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and randomized check of fetch_stage against a transaction-level model
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_1000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_in;
    logic        redirect_in;
    logic [31:0] redirect_pc_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_ready_in;
    logic        imem_resp_valid_in;
    logic [31:0] imem_resp_data_in;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4_out;
    logic        xcpt_out;

    int n_vec = 0;
    int n_err = 0;

    // Model state: a fetch is either being offered, in flight, or parked awaiting the stall to drop.
    logic [31:0] m_pc;
    bit          m_in_flight;
    bit          m_parked;
    bit          m_stale;
    logic [31:0] m_word;
    bit          m_xcpt;

    fetch_stage #(
        .XLEN(32), .ILEN(32), .RESET_PC(RESET_PC), .NOP_INSTR(NOP)
    ) dut (
        .clk(clk), .reset(reset), .stall_in(stall_in), .redirect_in(redirect_in),
        .redirect_pc_in(redirect_pc_in), .imem_req_out(imem_req_out),
        .imem_addr_out(imem_addr_out), .imem_ready_in(imem_ready_in),
        .imem_resp_valid_in(imem_resp_valid_in), .imem_resp_data_in(imem_resp_data_in),
        .instr_out(instr_out), .pc_out(pc_out), .pc_plus4_out(pc_plus4_out),
        .xcpt_out(xcpt_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input bit rst, input bit stl, input bit rdr, input logic [31:0] rpc,
                          input bit rdy, input bit rv, input logic [31:0] dat);
        reset = rst; stall_in = stl; redirect_in = rdr; redirect_pc_in = rpc;
        imem_ready_in = rdy; imem_resp_valid_in = rv; imem_resp_data_in = dat;
    endtask

    // Compare every output against what the model predicts for the current inputs.
    task automatic settle();
        logic        e_req;
        logic [31:0] e_instr;
        @(negedge clk);
        e_req   = !reset && !m_in_flight && !m_parked && !redirect_in;
        e_instr = NOP;
        if (!reset) begin
            if (m_parked && !redirect_in)
                e_instr = m_word;
            else if (m_in_flight && imem_resp_valid_in && !m_stale && !stall_in && !redirect_in)
                e_instr = imem_resp_data_in;
        end
        check("req",   {31'd0, imem_req_out}, {31'd0, e_req});
        check("addr",  imem_addr_out, m_pc);
        check("pc",    pc_out, m_pc);
        check("pc4",   pc_plus4_out, m_pc + 32'd4);
        check("instr", instr_out, e_instr);
        check("xcpt",  {31'd0, xcpt_out}, {31'd0, m_xcpt});
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            m_pc = RESET_PC; m_in_flight = 0; m_parked = 0; m_stale = 0; m_word = NOP; m_xcpt = 0;
        end else begin
            m_xcpt = redirect_in && (redirect_pc_in[1:0] != 2'b00);
            if (redirect_in) begin
                m_pc = redirect_pc_in;
                m_parked = 0;
                if (m_in_flight && !imem_resp_valid_in) begin
                    m_stale = 1;
                end else begin
                    m_in_flight = 0;
                    m_stale = 0;
                end
            end else if (m_parked) begin
                if (!stall_in) begin
                    m_parked = 0;
                    m_pc = m_pc + 32'd4;
                end
            end else if (m_in_flight) begin
                if (imem_resp_valid_in) begin
                    m_in_flight = 0;
                    if (m_stale) m_stale = 0;
                    else if (stall_in) begin m_parked = 1; m_word = imem_resp_data_in; end
                    else m_pc = m_pc + 32'd4;
                end
            end else if (imem_ready_in) begin
                m_in_flight = 1;
            end
        end
        #1;
    endtask

    task automatic cyc(input bit rst, input bit stl, input bit rdr, input logic [31:0] rpc,
                       input bit rdy, input bit rv, input logic [31:0] dat);
        set_in(rst, stl, rdr, rpc, rdy, rv, dat);
        settle();
        tick();
    endtask

    initial begin
        logic [31:0] held_pc;
        set_in(1, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        m_pc = RESET_PC; m_in_flight = 0; m_parked = 0; m_stale = 0; m_word = NOP; m_xcpt = 0;
        // Reset also overrides a redirect presented at the same time.
        set_in(1, 0, 1, 32'h0000_7777, 1, 1, 32'hDEAD_BEEF);
        settle();
        check("rst_req",   {31'd0, imem_req_out}, 32'd0);
        check("rst_instr", instr_out, NOP);
        check("rst_pc",    pc_out, 32'h0000_1000);
        tick();

        // Zero-latency memory: accept, then respond next cycle.
        set_in(0, 0, 0, 0, 1, 0, 0); settle();
        check("first_addr", imem_addr_out, 32'h0000_1000);
        check("first_req",  {31'd0, imem_req_out}, 32'd1);
        tick();
        set_in(0, 0, 0, 0, 0, 1, 32'h0050_0093); settle();
        check("first_instr", instr_out, 32'h0050_0093);
        check("first_pc",    pc_out, 32'h0000_1000);
        tick();
        set_in(0, 0, 0, 0, 1, 0, 0); settle();
        check("second_addr", imem_addr_out, 32'h0000_1004);
        tick();

        // Response arrives under stall; word is held until stall drops.
        cyc(0, 1, 0, 0, 0, 1, 32'hA5A5_0001);
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, 0, 0, 1, 0, 0); settle();
            check("hold_instr", instr_out, 32'hA5A5_0001);
            check("hold_pc",    pc_out, 32'h0000_1004);
            check("hold_req",   {31'd0, imem_req_out}, 32'd0);
            tick();
        end
        set_in(0, 0, 0, 0, 0, 0, 0); settle();
        check("release_instr", instr_out, 32'hA5A5_0001);
        tick();
        set_in(0, 0, 0, 0, 1, 0, 0); settle();
        check("release_addr", imem_addr_out, 32'h0000_1008);
        tick();

        // Redirect while waiting: the late response must be dropped.
        cyc(0, 0, 1, 32'h0000_2000, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0);
        set_in(0, 0, 0, 0, 0, 1, 32'h1111_2222); settle();
        check("killed_instr", instr_out, NOP);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0); settle();
        check("redir_addr", imem_addr_out, 32'h0000_2000);
        check("redir_req",  {31'd0, imem_req_out}, 32'd1);
        tick();

        // Misaligned target raises a one-cycle exception.
        cyc(0, 0, 1, 32'h0000_3002, 0, 0, 0);
        set_in(0, 0, 0, 0, 0, 0, 0); settle();
        check("xcpt_set", {31'd0, xcpt_out}, 32'd1);
        check("xcpt_pc",  pc_out, 32'h0000_3002);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0); settle();
        check("xcpt_clr", {31'd0, xcpt_out}, 32'd0);
        tick();

        // PC wrap at the top of the address space.
        cyc(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        set_in(0, 0, 0, 0, 0, 1, 32'h0000_0033); settle();
        check("wrap_pc4", pc_plus4_out, 32'h0000_0000);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0); settle();
        check("wrap_addr", imem_addr_out, 32'h0000_0000);
        tick();

        // Memory not ready: request held with a stable address.
        held_pc = 32'h0000_0000;
        for (int i = 0; i < 5; i++) begin
            set_in(0, 0, 0, 0, 0, 0, 0); settle();
            check("busy_req",   {31'd0, imem_req_out}, 32'd1);
            check("busy_addr",  imem_addr_out, held_pc);
            check("busy_instr", instr_out, NOP);
            tick();
        end

        // Random traffic, including resets landing mid-fetch and stray responses.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            tgt = $urandom;
            if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0,
                $urandom_range(0, 7) == 0, tgt,
                $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
- REQ-001: Parameter RESET_PC, 32'h0000_1000, PC loaded on reset.
- REQ-002: Parameter NOP_INSTR, brisc_pkg NOP, instruction driven when no valid fetch is presented.
- REQ-003: clk  in  1  single clock; all state updates on rising edge.
- REQ-004: reset  in  1  synchronous, active-high.
- REQ-005: stall_in  in  1  downstream stall; hold presented instruction and PC.
- REQ-006: redirect_in  in  1  taken branch/jump from EX; redirects fetch.
- REQ-007: redirect_pc_in  in  XLEN  redirect target address.
- REQ-008: imem_req_out  out  1  instruction memory request valid.
- REQ-009: imem_addr_out  out  XLEN  request address, equals pc_out.
- REQ-010: imem_ready_in  in  1  memory accepts request this cycle.
- REQ-011: imem_resp_valid_in  in  1  response data valid.
- REQ-012: imem_resp_data_in  in  ILEN  fetched instruction word.
- REQ-013: instr_out  out  ILEN  instruction to decode.
- REQ-014: pc_out  out  XLEN  address of instr_out / current fetch PC.
- REQ-015: pc_plus4_out  out  XLEN  pc_out + 4.
- REQ-016: xcpt_out  out  1  misaligned redirect target.

Function
- REQ-017: FSM states REQ (issuing), WAIT (request accepted, awaiting response), HOLD (instruction buffered under stall); one kill flag.
- REQ-018: REQ: imem_req_out = ~redirect_in; imem_ready_in & imem_req_out -> WAIT next cycle; else remain REQ.
- REQ-019: WAIT: imem_req_out = 0; no second request outstanding.
- REQ-020: WAIT, resp_valid, kill=0, stall_in=0, redirect_in=0: instr_out = imem_resp_data_in same cycle (combinational), pc <= pc+4, -> REQ.
- REQ-021: WAIT, resp_valid, kill=0, stall_in=1, redirect_in=0: capture response into ibuf, -> HOLD; pc unchanged.
- REQ-022: HOLD: instr_out = ibuf; stall_in=0 -> pc <= pc+4, -> REQ; stall_in=1 -> remain HOLD.
- REQ-023: instr_out = NOP_INSTR in all other cycles (REQ, WAIT without usable response); pc_out = pc register always.
- REQ-024: Redirect priority over stall_in and response: pc <= redirect_pc_in; next state REQ, except WAIT without resp_valid -> stay WAIT with kill <= 1.
- REQ-025: Redirect in WAIT with resp_valid same cycle: response dropped, instr_out = NOP_INSTR, -> REQ, kill stays 0.
- REQ-026: Redirect in HOLD: ibuf discarded, instr_out = NOP_INSTR that cycle.
- REQ-027: WAIT with kill=1 and resp_valid: response dropped, instr_out = NOP_INSTR, kill <= 0, -> REQ; pc not incremented.
- REQ-028: imem_resp_valid_in outside WAIT ignored.
- REQ-029: PC arithmetic modulo 2^XLEN; 32'hFFFF_FFFC + 4 wraps to 0.
- REQ-030: xcpt_out registered: asserted exactly one cycle after a redirect with redirect_pc_in[1:0] != 0; target still loaded.
- REQ-031: Best-case throughput: one instruction per 2 cycles with zero-latency memory (REQ accept, WAIT response).

Reset
- REQ-032: reset overrides all inputs incl. redirect_in.
- REQ-033: After reset: state REQ, pc = RESET_PC, kill = 0, xcpt_out = 0, ibuf = NOP_INSTR, instr_out = NOP_INSTR, imem_req_out = 0 during reset-asserted cycle.
- REQ-034: Reset in WAIT: outstanding response arriving after reset deassertion while in REQ ignored per REQ-028.

Verification
- REQ-035: Release reset, ready=1, resp next cycle 0x00500093 -> req addr 0x1000, instr_out 0x00500093 with pc_out 0x1000, then req addr 0x1004.
- REQ-036: Response during stall_in=1 for 3 cycles -> instr_out holds word, pc_out constant, no new request until stall drops, then addr +4.
- REQ-037: Redirect to 0x2000 in WAIT, response 2 cycles later -> response dropped (NOP out), next req addr 0x2000.
- REQ-038: Redirect to 0x3002 -> xcpt_out=1 exactly next cycle, pc_out 0x3002.
- REQ-039: Set pc 0xFFFF_FFFC via redirect, complete fetch -> next req addr 0x0000_0000, pc_plus4_out wraps.
- REQ-040: ready=0 for 5 cycles in REQ -> imem_req_out held high, address stable, instr_out NOP throughout.
